vram_loader: RTL and testbench
==============================

# vram_loader

Upstream fill stage for the 128x96 frame buffer that the VGA display path scans out at 5x scale. It accepts a stream of 3-bit RGB pixels over a valid/ready handshake and turns each accepted beat into one VRAM write at address {row, col}. Row-major order, resynchronised by a start-of-frame flag. Writes can be restricted to display blanking so the scan-out never shows a half-updated frame.

## Interface
- H_PIX, 128, pixels per row; the column counter wraps here.
- V_PIX, 96, rows per frame; the frame completes here.
- SYNC_TO_BLANK, 1, when 1 beats are accepted only while `blank`=1; when 0 `blank` is ignored.

- clk  in  1  system clock, the same clock as the display path.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  source presents a pixel.
- in_ready  out  1  loader can accept a pixel.
- in_sof  in  1  qualifies the current beat as pixel (0,0) of a new frame.
- in_rgb  in  3  pixel {R,G,B}.
- blank  in  1  display is outside its active area (from the VGA timing logic).
- wr_en  out  1  VRAM write strobe.
- wr_addr  out  14  {row[6:0], col[6:0]}; same packing as the display read address.
- wr_rgb  out  3  write data.
- frame_done  out  1  one-cycle pulse on the final write of a frame.
- sof_err  out  1  one-cycle pulse when `in_sof` arrives mid-frame.

## Operation
- Accept condition: accept = in_valid & in_ready.
- Ready condition: in_ready = (state != DONE) & (blank | !SYNC_TO_BLANK). It is combinational from registered state and `blank`.
- FSM states: IDLE, LOAD, DONE.
- **IDLE**
  - Beats accepted without `in_sof` are discarded (no write).
  - A beat accepted with `in_sof` writes (0,0), sets col=1, row=0, and moves to LOAD.
- **LOAD**
  - Each accepted beat writes at the current (row, col).
  - col increments. At col = H_PIX-1, col wraps to 0 and row increments.
  - The beat written at (V_PIX-1, H_PIX-1) moves the FSM to DONE.
- **LOAD, mid-frame `in_sof`** (any accepted beat with `in_sof`=1 that is not at (0,0)):
  - Restart: the pixel is written at (0,0) and col=1, row=0.
  - `sof_err` pulses.
  - The FSM stays in LOAD.
- **DONE**: in_ready=0 for one cycle, then IDLE.
- Counter widths: col and row are 7 bits. Counts never reach H_PIX or V_PIX, so there is no out-of-range address.
- **Reset** (reset=0 at a clk edge):
  - state=IDLE, col=0, row=0.
  - wr_en, wr_addr, wr_rgb, frame_done and sof_err all 0.
  - A frame in progress is aborted with no `frame_done`, and the next frame needs `in_sof`.
- `blank` dropping mid-frame only stalls acceptance; the position is held.

## Timing
- All outputs except `in_ready` are registered.
- Write latency is 1: a beat accepted at edge N gives wr_en=1 with its wr_addr/wr_rgb during cycle N..N+1 (visible after edge N).
- wr_en is high exactly one cycle per written beat. It is low for discarded beats and stall cycles.
- Throughput is one pixel per clock while accept holds. A full frame is 12288 beats minimum.
- frame_done is coincident with the wr_en of pixel (95,127).
- in_ready is 0 in the cycle after that write (DONE), and 1 again the following cycle (IDLE, subject to `blank`).
- sof_err is coincident with the wr_en of the restarted (0,0) write.
- The source must hold in_valid, in_sof and in_rgb stable until accepted.

## Structure
- Shared package `vga_pkg` holds:
  - H_PIX=128, V_PIX=96, ADDR_W=14, RGB_W=3.
  - The loader state enum {IDLE, LOAD, DONE}.
- Sub-module `pix_addr_counter`:
  - Inputs: clk, reset, inc, clr_to_one.
  - Outputs: col[6:0], row[6:0], last (row=V_PIX-1 & col=H_PIX-1).
  - Wraps col into row.
- The top holds the FSM, the ready logic and the output registers.

## Test plan
- Reset: hold reset=0 for 3 cycles with in_valid=1 -> all outputs 0, in_ready reflects IDLE & blank, no wr_en.
- Full frame, blank=1, continuous valid, sof on the first beat -> 12288 writes with addresses 0x0000..{95,127} in row-major order. frame_done pulses with the last write; in_ready=0 for exactly one cycle after.
- Pre-sof garbage: 5 beats without sof, then sof -> first wr_en carries addr 0 and the sof beat's rgb; the 5 beats are never written.
- Blank gating, SYNC_TO_BLANK=1: toggle blank 10 high / 20 low during a frame -> no accept or write while blank=0; addresses are contiguous across stalls.
- Mid-frame sof at pixel (3,17) -> that beat is written to addr 0, sof_err pulses once, the next write goes to addr 1, and no frame_done.
- Reset mid-frame after 500 writes -> outputs are 0 next cycle; beats without sof are discarded; a following sof frame completes normally with frame_done.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared frame-buffer geometry, pixel format and loader state encoding.
package vga_pkg;

    localparam int H_PIX   = 128;
    localparam int V_PIX   = 96;
    localparam int ADDR_W  = 14;
    localparam int RGB_W   = 3;
    localparam int COORD_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } load_state_t;

    // Same packing the display path uses for its read address.
    function automatic logic [ADDR_W-1:0] pack_addr(input logic [COORD_W-1:0] row,
                                                    input logic [COORD_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/vram_loader_if.sv
// Pixel stream (valid/ready) plus the VRAM write port driven by the loader.
interface vram_loader_if;

    logic                      in_valid;
    logic                      in_ready;
    logic                      in_sof;
    logic [vga_pkg::RGB_W-1:0] in_rgb;

    logic                       wr_en;
    logic [vga_pkg::ADDR_W-1:0] wr_addr;
    logic [vga_pkg::RGB_W-1:0]  wr_rgb;

    modport master (
        output in_valid,
        output in_sof,
        output in_rgb,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_rgb
    );

    modport slave (
        input  in_valid,
        input  in_sof,
        input  in_rgb,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_rgb
    );

endinterface

// File: rtl/pix_addr_counter.sv
// Row-major (row, col) position counter for the frame buffer; col wraps into row.
module pix_addr_counter
    import vga_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               clr_to_one,
    output logic [COORD_W-1:0] col,
    output logic [COORD_W-1:0] row,
    output logic               last
);

    localparam logic [COORD_W-1:0] COL_MAX = COORD_W'(H_PIX - 1);
    localparam logic [COORD_W-1:0] ROW_MAX = COORD_W'(V_PIX - 1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            col <= '0;
            row <= '0;
        end else if (clr_to_one) begin
            // The (0,0) pixel is written by the same beat, so the next one lands at col 1.
            col <= COORD_W'(1);
            row <= '0;
        end else if (inc) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + COORD_W'(1);
            end else begin
                col <= col + COORD_W'(1);
            end
        end
    end

    assign last = (row == ROW_MAX) && (col == COL_MAX);

endmodule

// File: rtl/vram_loader.sv
// Streams RGB pixels into the VRAM in row-major order, optionally only during blanking.
//
// state | meaning
// IDLE  | waiting for a start-of-frame beat; beats without sof are dropped
// LOAD  | writing each accepted beat at the current (row, col)
// DONE  | one cycle after the final pixel; input stalled, then back to IDLE
module vram_loader
    import vga_pkg::*;
#(
    parameter bit SYNC_TO_BLANK = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          blank,
    vram_loader_if.slave  bus,
    output logic          frame_done,
    output logic          sof_err
);

    load_state_t        state;
    logic [COORD_W-1:0] col;
    logic [COORD_W-1:0] row;
    logic               last;
    logic               accept;
    logic               sof_beat;
    logic               pix_beat;
    logic               inc;
    logic               pos_zero;

    assign bus.in_ready = (state != DONE) && (blank || !SYNC_TO_BLANK);
    assign accept       = bus.in_valid && bus.in_ready;
    assign sof_beat     = accept && bus.in_sof;
    assign pix_beat     = accept && !bus.in_sof && (state == LOAD);
    assign inc          = pix_beat;
    assign pos_zero     = (row == '0) && (col == '0);

    pix_addr_counter u_addr_cnt (
        .clk        (clk),
        .reset      (reset),
        .inc        (inc),
        .clr_to_one (sof_beat),
        .col        (col),
        .row        (row),
        .last       (last)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_rgb  <= '0;
            frame_done  <= 1'b0;
            sof_err     <= 1'b0;
        end else begin
            bus.wr_en  <= 1'b0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (sof_beat) begin
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= '0;
                        bus.wr_rgb  <= bus.in_rgb;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    if (sof_beat) begin
                        // Resynchronise on an unexpected sof rather than finishing a torn frame.
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= '0;
                        bus.wr_rgb  <= bus.in_rgb;
                        sof_err     <= !pos_zero;
                    end else if (pix_beat) begin
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= pack_addr(row, col);
                        bus.wr_rgb  <= bus.in_rgb;
                        if (last) begin
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_loader.sv
// Directed bench for vram_loader: vector table plus frame-level sequences.
module tb_vram_loader;

    logic clk;
    logic reset;
    logic blank;
    logic frame_done;
    logic sof_err;

    int checks;
    int errors;

    vram_loader_if bus ();

    vram_loader #(.SYNC_TO_BLANK(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .blank      (blank),
        .bus        (bus),
        .frame_done (frame_done),
        .sof_err    (sof_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        sof;
        logic [2:0]  rgb;
        logic        blnk;
        logic        exp_ready;
        logic        exp_wr;
        logic [13:0] exp_addr;
        logic [2:0]  exp_rgb;
        logic        exp_err;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mk(input logic v, input logic s, input logic [2:0] rgb, input logic b,
                                input logic er, input logic ew, input logic [13:0] ea,
                                input logic [2:0] eg, input logic ee);
        vec_t t;
        t.valid = v; t.sof = s; t.rgb = rgb; t.blnk = b;
        t.exp_ready = er; t.exp_wr = ew; t.exp_addr = ea; t.exp_rgb = eg; t.exp_err = ee;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_rgb   = 3'd0;
        blank        = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    // Drives n back-to-back beats with blank=1; sof on beat 0 and on beat restart_at.
    task automatic stream_beats(input int n, input int restart_at,
                                output int bad, output int errs, output int dones);
        int pos;
        logic [13:0] ea;
        logic        s;
        bad = 0; errs = 0; dones = 0; pos = 0;
        for (int i = 0; i < n; i++) begin
            s            = (i == 0) || (i == restart_at);
            blank        = 1'b1;
            bus.in_valid = 1'b1;
            bus.in_sof   = s;
            bus.in_rgb   = 3'(i * 5);
            if (s) begin
                ea  = 14'd0;
                pos = 1;
            end else begin
                ea  = 14'(pos);
                pos = pos + 1;
            end
            @(posedge clk); #1;
            if (bus.wr_en !== 1'b1 || bus.wr_addr !== ea || bus.wr_rgb !== 3'(i * 5)) bad++;
            if (frame_done !== ((!s && ea == 14'd12287) ? 1'b1 : 1'b0)) bad++;
            if (sof_err !== ((s && i != 0) ? 1'b1 : 1'b0)) bad++;
            if (sof_err === 1'b1) errs++;
            if (frame_done === 1'b1) dones++;
        end
    endtask

    int bad, errs, dones, nwr;

    initial begin
        checks = 0;
        errors = 0;

        // Reset held 3 cycles with the source pushing a sof beat.
        reset        = 1'b0;
        blank        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_sof   = 1'b1;
        bus.in_rgb   = 3'd7;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en",      32'(bus.wr_en),   32'd0);
        check("rst_wr_addr",    32'(bus.wr_addr), 32'd0);
        check("rst_wr_rgb",     32'(bus.wr_rgb),  32'd0);
        check("rst_frame_done", 32'(frame_done),  32'd0);
        check("rst_sof_err",    32'(sof_err),     32'd0);
        check("rst_ready_blank1", 32'(bus.in_ready), 32'd1);
        blank = 1'b0;
        #1;
        check("rst_ready_blank0", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        blank        = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;

        vecs[0] = mk(1, 0, 3'd5, 1, 1, 0, 14'd0, 3'd0, 0);
        vecs[1] = mk(1, 0, 3'd3, 0, 0, 0, 14'd0, 3'd0, 0);
        vecs[2] = mk(1, 1, 3'd6, 1, 1, 1, 14'd0, 3'd6, 0);
        vecs[3] = mk(1, 0, 3'd2, 1, 1, 1, 14'd1, 3'd2, 0);
        vecs[4] = mk(0, 0, 3'd0, 1, 1, 0, 14'd0, 3'd0, 0);
        vecs[5] = mk(1, 0, 3'd7, 0, 0, 0, 14'd0, 3'd0, 0);
        vecs[6] = mk(1, 0, 3'd7, 1, 1, 1, 14'd2, 3'd7, 0);
        vecs[7] = mk(1, 1, 3'd4, 1, 1, 1, 14'd0, 3'd4, 1);
        vecs[8] = mk(1, 0, 3'd1, 1, 1, 1, 14'd1, 3'd1, 0);
        vecs[9] = mk(1, 0, 3'd3, 1, 1, 1, 14'd2, 3'd3, 0);

        for (int k = 0; k < 10; k++) begin
            bus.in_valid = vecs[k].valid;
            bus.in_sof   = vecs[k].sof;
            bus.in_rgb   = vecs[k].rgb;
            blank        = vecs[k].blnk;
            #1;
            check($sformatf("vec%0d_ready", k), 32'(bus.in_ready), 32'(vecs[k].exp_ready));
            @(posedge clk); #1;
            check($sformatf("vec%0d_wr_en", k), 32'(bus.wr_en), 32'(vecs[k].exp_wr));
            if (vecs[k].exp_wr) begin
                check($sformatf("vec%0d_addr", k), 32'(bus.wr_addr), 32'(vecs[k].exp_addr));
                check($sformatf("vec%0d_rgb", k),  32'(bus.wr_rgb),  32'(vecs[k].exp_rgb));
            end
            check($sformatf("vec%0d_sof_err", k), 32'(sof_err), 32'(vecs[k].exp_err));
        end

        // Full frame at full rate, then the one-cycle DONE stall.
        reset_dut();
        stream_beats(12288, -1, bad, errs, dones);
        check("frame_seq",        32'(bad),   32'd0);
        check("frame_done_count", 32'(dones), 32'd1);
        check("frame_sof_err",    32'(errs),  32'd0);
        bus.in_sof = 1'b0;
        check("done_ready_low", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        check("done_no_write",   32'(bus.wr_en),    32'd0);
        check("idle_ready_high", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        check("idle_drop_no_sof", 32'(bus.wr_en), 32'd0);

        // Blank gating: 10 cycles open, 20 stalled.
        reset_dut();
        bad = 0; nwr = 0;
        for (int c = 0; c < 300; c++) begin
            blank        = ((c % 30) < 10);
            bus.in_valid = 1'b1;
            bus.in_sof   = (nwr == 0);
            bus.in_rgb   = 3'(c);
            #1;
            if (bus.in_ready !== blank) bad++;
            @(posedge clk); #1;
            if (blank) begin
                if (bus.wr_en !== 1'b1 || bus.wr_addr !== 14'(nwr) || bus.wr_rgb !== 3'(c)) bad++;
            end else if (bus.wr_en !== 1'b0) begin
                bad++;
            end
            if (bus.wr_en === 1'b1) nwr++;
        end
        check("blank_gate",   32'(bad), 32'd0);
        check("blank_writes", 32'(nwr), 32'd100);

        // Mid-frame sof at (3,17) = beat 401, then one more beat.
        reset_dut();
        stream_beats(403, 401, bad, errs, dones);
        check("midsof_seq",        32'(bad),   32'd0);
        check("midsof_err_count",  32'(errs),  32'd1);
        check("midsof_no_done",    32'(dones), 32'd0);
        check("midsof_next_addr",  32'(bus.wr_addr), 32'd1);

        // Reset after 500 writes aborts the frame.
        reset_dut();
        stream_beats(500, -1, bad, errs, dones);
        check("abort_pre_seq", 32'(bad), 32'd0);
        reset        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sof   = 1'b0;
        bus.in_rgb   = 3'd5;
        @(posedge clk); #1;
        check("abort_wr_en",   32'(bus.wr_en),   32'd0);
        check("abort_addr",    32'(bus.wr_addr), 32'd0);
        check("abort_rgb",     32'(bus.wr_rgb),  32'd0);
        check("abort_done",    32'(frame_done),  32'd0);
        reset = 1'b1;
        nwr = 0;
        for (int j = 0; j < 3; j++) begin
            bus.in_rgb = 3'(j + 1);
            @(posedge clk); #1;
            if (bus.wr_en === 1'b1) nwr++;
        end
        check("abort_drop_no_sof", 32'(nwr), 32'd0);
        stream_beats(12288, -1, bad, errs, dones);
        check("after_abort_seq",  32'(bad),   32'd0);
        check("after_abort_done", 32'(dones), 32'd1);

        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
